// File: rtl/modulo_varredura_mux8_pkg.sv
`default_nettype none
// ============================================================================
// modulo_varredura_mux8_pkg : shared types and widths for the mux scan block
// Revision: 1.0
// ============================================================================
package modulo_varredura_mux8_pkg;

    localparam int STEP_W = 4;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // The final sample bypasses the shadow register and lands straight in the MSB.
    function automatic logic [DATA_W-1:0] assemble_word(
        input logic [DATA_W-2:0] shadow,
        input logic              last_bit
    );
        return {last_bit, shadow};
    endfunction

endpackage
`default_nettype wire

// File: rtl/modulo_varredura_mux8_if.sv
`default_nettype none
// ============================================================================
// modulo_varredura_mux8_if : mux select/sample path plus valid/ready word port
// Revision: 1.0
// ============================================================================
interface modulo_varredura_mux8_if;
    import modulo_varredura_mux8_pkg::*;

    logic              start;
    logic              continuous;
    logic              mux_out;
    logic              ready;
    logic [IDX_W-1:0]  sel;
    logic              busy;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              changed;

    modport master (
        input  start,
        input  continuous,
        input  mux_out,
        input  ready,
        output sel,
        output busy,
        output data,
        output valid,
        output changed
    );

    modport slave (
        output start,
        output continuous,
        output mux_out,
        output ready,
        input  sel,
        input  busy,
        input  data,
        input  valid,
        input  changed
    );

endinterface
`default_nettype wire

// File: rtl/modulo_varredura_mux8_contador_passo.sv
`default_nettype none
// ============================================================================
// modulo_contador_passo : dwell counter with clear/enable and terminal count
// Revision: 1.0
// ============================================================================
module modulo_contador_passo
    import modulo_varredura_mux8_pkg::*;
#(
    parameter int STEP_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      tc
);

    localparam logic [STEP_W-1:0] TC_VALUE = STEP_W'(STEP_CYCLES - 1);

    logic [STEP_W-1:0] count_q;
    logic [STEP_W-1:0] count_d;

    // Clear wins over enable so the terminal cycle restarts the dwell at zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/modulo_varredura_mux8.sv
`default_nettype none
// ============================================================================
// modulo_varredura_mux8 : steps an 8:1 mux select, packs the samples into a
// byte and hands it downstream over valid/ready.   Revision: 1.0
// ============================================================================
module modulo_varredura_mux8
    import modulo_varredura_mux8_pkg::*;
#(
    parameter int STEP_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    modulo_varredura_mux8_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  sel_d;
    logic [DATA_W-2:0] shadow_q;
    logic [DATA_W-2:0] shadow_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              busy_q;
    logic              busy_d;
    logic              changed_q;
    logic              changed_d;

    logic              step_tc_w;
    logic              step_en_w;
    logic              step_clr_w;
    logic [DATA_W-1:0] word_w;

    assign step_en_w  = (state_q == ST_SCAN);
    assign step_clr_w = (state_q != ST_SCAN) || step_tc_w;

    modulo_contador_passo #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_contador_passo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (step_clr_w),
        .en    (step_en_w),
        .tc    (step_tc_w)
    );

    assign word_w = assemble_word(shadow_q, bus.mux_out);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        valid_d   = valid_q;
        changed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (step_tc_w) begin
                    if (idx_q == LAST_IDX) begin
                        data_d    = word_w;
                        valid_d   = 1'b1;
                        changed_d = (word_w != data_q);
                        state_d   = ST_HOLD;
                    end else begin
                        shadow_d[idx_q] = bus.mux_out;
                        idx_d           = idx_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Stalled here until accepted; nothing is sampled meanwhile.
                if (bus.ready) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = bus.continuous ? ST_SCAN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        sel_d  = (state_d == ST_SCAN) ? idx_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sel_q     <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            changed_q <= changed_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_varredura_mux8.sv
`default_nettype none
// ============================================================================
// tb_modulo_varredura_mux8 : bench for the mux scan controller, STEP 2 and 1
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_modulo_varredura_mux8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    modulo_varredura_mux8_if bus2 ();
    modulo_varredura_mux8_if bus1 ();

    logic [7:0] pat2 = 8'h00;
    logic [7:0] pat1 = 8'h00;

    // Mux models: output is bit sel of the input bank pattern.
    assign bus2.mux_out = pat2[bus2.sel];
    assign bus1.mux_out = pat1[bus1.sel];

    modulo_varredura_mux8 #(.STEP_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    modulo_varredura_mux8 #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    logic [7:0] prev2 = 8'h00;
    logic [7:0] prev1 = 8'h00;

    typedef struct {
        logic [7:0] pattern;
        logic [7:0] exp_data;
        logic       exp_changed;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid2(output int lat, output logic sel_ok);
        int n;
        n = 0;
        sel_ok = 1'b1;
        while (!bus2.valid && n < 200) begin
            if (bus2.sel !== 3'(n / 2)) sel_ok = 1'b0;
            tick();
            n++;
        end
        lat = n;
    endtask

    task automatic scan2(input logic [7:0] p, output int lat, output logic sel_ok);
        pat2 = p;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        wait_valid2(lat, sel_ok);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        int          stall;
        logic        ok;
        logic [7:0]  p;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'hA5, 8'hA5, 1'b0};
        vecs[2] = '{8'h5A, 8'h5A, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b1};
        vecs[7] = '{8'h01, 8'h01, 1'b1};

        bus2.start = 1'b0; bus2.continuous = 1'b0; bus2.ready = 1'b1;
        bus1.start = 1'b0; bus1.continuous = 1'b0; bus1.ready = 1'b1;

        // Reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel",     bus2.sel,     0);
        check("rst_data",    bus2.data,    0);
        check("rst_valid",   bus2.valid,   0);
        check("rst_busy",    bus2.busy,    0);
        check("rst_changed", bus2.changed, 0);
        #20 rst_n = 1'b1;
        tick();

        // Table-driven single scans, STEP_CYCLES=2, ready held high.
        for (int i = 0; i < 8; i++) begin
            scan2(vecs[i].pattern, lat, ok);
            check("tbl_latency", lat, 16);
            check("tbl_sel_seq", ok, 1);
            check("tbl_data", bus2.data, vecs[i].exp_data);
            check("tbl_changed", bus2.changed, vecs[i].exp_changed);
            prev2 = vecs[i].exp_data;
            tick();
            check("tbl_valid_drop", bus2.valid, 0);
            check("tbl_idle", bus2.busy, 0);
        end

        // Backpressure in continuous mode.
        bus2.ready = 1'b0;
        bus2.continuous = 1'b1;
        scan2(8'h3C, lat, ok);
        check("bp_latency", lat, 16);
        check("bp_data", bus2.data, 8'h3C);
        check("bp_changed", bus2.changed, 32'(8'h3C != prev2));
        prev2 = 8'h3C;
        pat2 = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid_held", bus2.valid, 1);
            check("bp_data_stable", bus2.data, 8'h3C);
            check("bp_busy", bus2.busy, 1);
            check("bp_sel_zero", bus2.sel, 0);
            check("bp_changed_low", bus2.changed, 0);
        end
        bus2.ready = 1'b1;
        tick();
        bus2.continuous = 1'b0;
        check("bp_accept_valid", bus2.valid, 0);
        check("bp_rescan_busy", bus2.busy, 1);
        check("bp_rescan_sel", bus2.sel, 0);
        wait_valid2(lat, ok);
        check("bp_rescan_latency", lat, 16);
        check("bp_rescan_sel_seq", ok, 1);
        check("bp_rescan_data", bus2.data, 8'hC3);
        check("bp_rescan_changed", bus2.changed, 32'(8'hC3 != prev2));
        prev2 = 8'hC3;
        tick();
        check("bp_end_idle", bus2.busy, 0);

        // Abort a scan at sel==4 with an asynchronous reset.
        pat2 = 8'hFF;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        n = 0;
        while (bus2.sel != 3'd4 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_sel4", bus2.sel, 4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sel",     bus2.sel,     0);
        check("abort_data",    bus2.data,    0);
        check("abort_valid",   bus2.valid,   0);
        check("abort_busy",    bus2.busy,    0);
        check("abort_changed", bus2.changed, 0);
        prev2 = 8'h00;
        prev1 = 8'h00;
        #1 rst_n = 1'b1;
        tick();
        scan2(8'h12, lat, ok);
        check("abort_rescan_latency", lat, 16);
        check("abort_rescan_data", bus2.data, 8'h12);
        check("abort_rescan_changed", bus2.changed, 1);
        prev2 = 8'h12;
        tick();

        // Randomized scans with random stalls against the pattern model.
        for (int it = 0; it < 10; it++) begin
            bus2.ready = 1'b0;
            p = (($urandom_range(0, 3) == 0) ? prev2 : 8'($urandom));
            scan2(p, lat, ok);
            check("rnd2_latency", lat, 16);
            check("rnd2_data", bus2.data, p);
            check("rnd2_changed", bus2.changed, 32'(p != prev2));
            prev2 = p;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                pat2 = ~p;
                tick();
                check("rnd2_stall_data", bus2.data, p);
                check("rnd2_stall_valid", bus2.valid, 1);
            end
            bus2.ready = 1'b1;
            tick();
            check("rnd2_accept", bus2.valid, 0);
        end

        // STEP_CYCLES=1 with a stray start during the scan.
        pat1 = 8'h96;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 0;
        ok = 1'b1;
        while (!bus1.valid && n < 100) begin
            if (bus1.sel !== 3'(n)) ok = 1'b0;
            bus1.start = (n == 3);
            tick();
            n++;
        end
        bus1.start = 1'b0;
        check("s1_latency", n, 8);
        check("s1_sel_seq", ok, 1);
        check("s1_data", bus1.data, 8'h96);
        check("s1_changed", bus1.changed, 1);
        prev1 = 8'h96;
        tick();
        check("s1_valid_drop", bus1.valid, 0);
        check("s1_idle", bus1.busy, 0);

        // Continuous mode, ready high: one word every 9 cycles.
        bus1.continuous = 1'b1;
        p = 8'($urandom);
        pat1 = p;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.valid && n < 100) begin
            tick();
            n++;
        end
        check("cont_first_latency", n, 8);
        for (int it = 0; it < 12; it++) begin
            check("cont_data", bus1.data, p);
            check("cont_changed", bus1.changed, 32'(p != prev1));
            prev1 = p;
            if ($urandom_range(0, 3) != 0) p = 8'($urandom);
            pat1 = p;
            if (it == 11) bus1.continuous = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus1.valid && n < 50 && it != 11);
            if (it != 11) check("cont_period", n, 9);
        end
        check("cont_end_idle", bus1.busy, 0);
        check("cont_end_valid", bus1.valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulo_varredura_mux8.md
# modulo_varredura_mux8

Sequential scan controller that drives the 3-bit select of the 8:1 gate-level multiplexer and consumes its single-bit output. It steps the select through indices 0..7, samples the mux output at each index, and assembles the eight samples into a parallel word. The word is delivered downstream through a valid/ready handshake, so a serial-through-mux input bank reads back as one 8-bit value.

## Interface
- STEP_CYCLES, 2, clock cycles `sel` is held at each index; legal range 1..16; sampling occurs on the last of them.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; sampled only in IDLE.
- continuous  in  1  when 1, a new scan starts automatically after each handshake.
- mux_out  in  1  output of the 8:1 mux (combinational function of `sel`).
- sel  out  3  select driven to the mux.
- busy  out  1  high whenever state is not IDLE.
- data  out  8  captured word; data[i] = mux_out sampled while sel==i.
- valid  out  1  data available; held until accepted.
- ready  in  1  downstream accept; transfer occurs on an edge where valid && ready.
- changed  out  1  one-cycle pulse, coincident with valid rising, when the new word differs from the previous word.

## Operation
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - sel=0, busy=0, valid=0.
  - start=1 at an edge -> SCAN with idx=0 and step counter=0.
- SCAN:
  - sel=idx; step counter increments each cycle.
  - At counter==STEP_CYCLES-1, mux_out is written to shadow bit idx, the counter clears, and idx increments.
  - When idx==7 samples, the word {mux_out, shadow[6:0]} loads into data on that same edge; valid<=1; changed<=(new word != old data); -> HOLD.
- HOLD:
  - valid=1, data stable, sel=0.
  - On valid && ready: valid<=0, and the next state is SCAN (idx=0) if continuous=1, otherwise IDLE.
- Ignored inputs:
  - start is ignored in SCAN and HOLD.
  - continuous is sampled only at the handshake edge.
- Comparison baseline: the previous word is the current data register, which is 0x00 after reset. A first capture of 0x00 therefore gives changed=0.
- Reset: asynchronous and immediate. It aborts any scan, discards partial shadow bits, and forces state IDLE.
- Reset values: sel=0, data=0x00, valid=0, busy=0, changed=0.
- Widths: idx 3 bits (no wrap needed, because the last index exits SCAN); step counter 4 bits.

## Timing
- Scan latency: start accepted at edge E0 -> valid high after edge E0+8·STEP_CYCLES.
- Index k is presented from E0+k·STEP_CYCLES and sampled at edge E0+(k+1)·STEP_CYCLES.
- STEP_CYCLES=1: `sel` changes every cycle; each sample is taken in the same cycle the index is presented. The mux path must settle within one clock period.
- Handshake:
  - Acceptance happens on the edge where valid && ready; valid is low in the following cycle.
  - ready may be asserted before valid. With ready tied high, valid is a one-cycle pulse.
- Continuous mode throughput, ready=1: one word per 8·STEP_CYCLES+1 cycles (the extra cycle is HOLD).
- Backpressure: while ready=0, the block stalls in HOLD. No sampling occurs and data is unchanged, so no word is ever lost or overwritten.
- changed is high exactly one cycle: the first cycle of valid.

## Structure
- Shared include/package contents:
  - state encodings: IDLE=2'b00, SCAN=2'b01, HOLD=2'b10
  - STEP counter width constant (4)
  - mux index width (3)
- Sub-module `modulo_contador_passo`: step counter with clear/enable and a terminal-count output (counter==STEP_CYCLES-1). It is instantiated once.
- The top level holds the FSM, idx register, shadow[6:0], data, and the compare.

## Test plan
- Reset: assert rst_n=0 mid-operation -> all outputs read sel=0, data=0x00, valid=0, busy=0, changed=0, with no clock edge required.
- Single scan:
  - Setup: STEP_CYCLES=2, mux model returning bit i of 0xA5, start pulse, ready=1.
  - `sel` sequence: 0,0,1,1,…,7,7.
  - Result: valid after 16 cycles, data=0xA5, changed=1.
- Repeat detection: second start with the same pattern -> data=0xA5, changed=0. Then pattern 0x5A -> changed=1.
- Backpressure:
  - Setup: continuous=1, ready=0 for 5 cycles after valid.
  - While stalled: valid held, data stable, busy=1, sel=0, no sampling.
  - On ready=1: the next scan starts the following cycle with sel=0.
- Abort: rst_n pulsed low while sel==4 -> immediate reset values; a subsequent full scan returns the correct word with no stale shadow bits.
- STEP_CYCLES=1, with start re-pulsed during SCAN:
  - The extra start is ignored.
  - valid arrives 8 cycles after acceptance.
  - continuous=1, ready=1 gives a valid pulse every 9 cycles.
